// File: rtl/alu_hilo_if.sv
// EX-stage bus between the pipeline and alu_hilo: operands/control in, result, flags and HI/LO out.
interface alu_hilo_if;
  logic        ex_valid;
  logic        flush;
  logic [4:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic [31:0] result;
  logic        overflow;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output ex_valid, flush, alucontrol, a, b, sa,
    input  result, overflow, busy, hi_o, lo_o
  );

  modport slave (
    input  ex_valid, flush, alucontrol, a, b, sa,
    output result, overflow, busy, hi_o, lo_o
  );
endinterface

// File: rtl/alu_hilo.sv
// Execute-stage ALU with architectural HI/LO, single-cycle MULT/MULTU and an optional
// 32-step restoring divider for DIV/DIVU, built only when ALU_HILO_DIV_EN is defined.
module alu_hilo (
  input  logic      clk,
  input  logic      resetn,
  alu_hilo_if.slave bus
);
  localparam logic [4:0] AND_CONTROL     = 5'd0;
  localparam logic [4:0] OR_CONTROL      = 5'd1;
  localparam logic [4:0] XOR_CONTROL     = 5'd2;
  localparam logic [4:0] NOR_CONTROL     = 5'd3;
  localparam logic [4:0] ADD_CONTROL     = 5'd4;
  localparam logic [4:0] ADDU_CONTROL    = 5'd5;
  localparam logic [4:0] SUB_CONTROL     = 5'd6;
  localparam logic [4:0] SUBU_CONTROL    = 5'd7;
  localparam logic [4:0] SLT_CONTROL     = 5'd8;
  localparam logic [4:0] SLTU_CONTROL    = 5'd9;
  localparam logic [4:0] LUI_CONTROL     = 5'd10;
  localparam logic [4:0] SLL_CONTROL     = 5'd11;
  localparam logic [4:0] SRL_CONTROL     = 5'd12;
  localparam logic [4:0] SRA_CONTROL     = 5'd13;
  localparam logic [4:0] SLLV_CONTROL    = 5'd14;
  localparam logic [4:0] SRLV_CONTROL    = 5'd15;
  localparam logic [4:0] SRAV_CONTROL    = 5'd16;
  localparam logic [4:0] MFHI_CONTROL    = 5'd17;
  localparam logic [4:0] MFLO_CONTROL    = 5'd18;
  localparam logic [4:0] MTHI_CONTROL    = 5'd19;
  localparam logic [4:0] MTLO_CONTROL    = 5'd20;
  localparam logic [4:0] MULT_CONTROL    = 5'd21;
  localparam logic [4:0] MULTU_CONTROL   = 5'd22;
  localparam logic [4:0] DIV_CONTROL     = 5'd23;
  localparam logic [4:0] DIVU_CONTROL    = 5'd24;

  logic [31:0] a, b;
  logic [4:0]  op;
  logic [31:0] sum, diff, neg_b;
  logic [63:0] sprod, uprod;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_w;
  logic [31:0] res_w;
  logic        ovf_w;

  assign a     = bus.a;
  assign b     = bus.b;
  assign op    = bus.alucontrol;
  assign sum   = a + b;
  assign diff  = a - b;
  assign neg_b = '0 - b;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'h0, a} * {32'h0, b};

  always_comb begin
    res_w = '0;
    ovf_w = 1'b0;
    case (op)
      AND_CONTROL:   res_w = a & b;
      OR_CONTROL:    res_w = a | b;
      XOR_CONTROL:   res_w = a ^ b;
      NOR_CONTROL:   res_w = ~(a | b);
      ADD_CONTROL: begin
        res_w = sum;
        ovf_w = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ADDU_CONTROL:  res_w = sum;
      SUB_CONTROL: begin
        res_w = diff;
        ovf_w = (a[31] == neg_b[31]) && (diff[31] != a[31]);
      end
      SUBU_CONTROL:  res_w = diff;
      SLT_CONTROL:   res_w = {31'h0, $signed(a) < $signed(b)};
      SLTU_CONTROL:  res_w = {31'h0, a < b};
      LUI_CONTROL:   res_w = {b[15:0], 16'h0};
      SLL_CONTROL:   res_w = b << bus.sa;
      SRL_CONTROL:   res_w = b >> bus.sa;
      SRA_CONTROL:   res_w = $unsigned($signed(b) >>> bus.sa);
      SLLV_CONTROL:  res_w = b << a[4:0];
      SRLV_CONTROL:  res_w = b >> a[4:0];
      SRAV_CONTROL:  res_w = $unsigned($signed(b) >>> a[4:0]);
      MFHI_CONTROL:  res_w = hi_q;
      MFLO_CONTROL:  res_w = lo_q;
      MTHI_CONTROL:  res_w = a;
      MTLO_CONTROL:  res_w = a;
      default:       res_w = '0;
    endcase
  end

`ifdef ALU_HILO_DIV_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        qs_q, qs_d, rs_q, rs_d, dz_q, dz_d;
  logic        is_div, sgn, start;
  logic [32:0] rsh, rsub;
  logic [31:0] quo_fix, rem_fix;

  assign is_div  = (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  assign sgn     = (op == DIV_CONTROL);
  assign start   = bus.ex_valid && !bus.flush && is_div;
  assign busy_w  = ((st_q == ST_IDLE) && start) || (st_q == ST_RUN);
  assign rsh     = {rem_q, quo_q[31]};
  // rsh - dvs always fits 32 bits when non-negative, so bit 32 is a clean borrow flag.
  assign rsub    = rsh - {1'b0, dvs_q};
  assign quo_fix = qs_q ? ('0 - quo_q) : quo_q;
  assign rem_fix = rs_q ? ('0 - rem_q) : rem_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    qs_d  = qs_q;
    rs_d  = rs_q;
    dz_d  = dz_q;
    case (st_q)
      ST_IDLE: if (start) begin
        quo_d = (sgn && a[31]) ? ('0 - a) : a;
        dvs_d = (sgn && b[31]) ? ('0 - b) : b;
        rem_d = '0;
        qs_d  = sgn && (a[31] ^ b[31]);
        rs_d  = sgn && a[31];
        dz_d  = (b == '0);
        cnt_d = '0;
        st_d  = ST_RUN;
      end
      ST_RUN: begin
        rem_d = rsub[32] ? rsh[31:0] : rsub[31:0];
        quo_d = {quo_q[30:0], ~rsub[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) st_d = ST_DONE;
      end
      default: st_d = ST_IDLE;
    endcase
    if (bus.flush) st_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      qs_q  <= 1'b0;
      rs_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      qs_q  <= qs_d;
      rs_q  <= rs_d;
      dz_q  <= dz_d;
    end
  end
`else
  assign busy_w = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.ex_valid && !bus.flush && !busy_w) begin
      case (op)
        MTHI_CONTROL:  hi_d = a;
        MTLO_CONTROL:  lo_d = a;
        MULT_CONTROL:  {hi_d, lo_d} = sprod;
        MULTU_CONTROL: {hi_d, lo_d} = uprod;
        default: ;
      endcase
    end
`ifdef ALU_HILO_DIV_EN
    if ((st_q == ST_DONE) && !bus.flush && !dz_q) begin
      lo_d = quo_fix;
      hi_d = rem_fix;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.result   = res_w;
  assign bus.overflow = ovf_w;
  assign bus.busy     = busy_w;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
endmodule

// File: tb/tb_alu_hilo.sv
// Randomized self-checking bench for alu_hilo against a behavioural HI/LO/ALU model;
// divider expectations follow ALU_HILO_DIV_EN.
module tb_alu_hilo;
  localparam logic [4:0] C_AND = 5'd0,  C_OR = 5'd1,   C_XOR = 5'd2,  C_NOR = 5'd3;
  localparam logic [4:0] C_ADD = 5'd4,  C_ADDU = 5'd5, C_SUB = 5'd6,  C_SUBU = 5'd7;
  localparam logic [4:0] C_SLT = 5'd8,  C_SLTU = 5'd9, C_LUI = 5'd10, C_SLL = 5'd11;
  localparam logic [4:0] C_SRL = 5'd12, C_SRA = 5'd13, C_SLLV = 5'd14, C_SRLV = 5'd15;
  localparam logic [4:0] C_SRAV = 5'd16, C_MFHI = 5'd17, C_MFLO = 5'd18, C_MTHI = 5'd19;
  localparam logic [4:0] C_MTLO = 5'd20, C_MULT = 5'd21, C_MULTU = 5'd22;
  localparam logic [4:0] C_DIV = 5'd23, C_DIVU = 5'd24, C_USELESS = 5'd25;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_hi, m_lo;

  alu_hilo_if bus ();
  alu_hilo dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_res(input logic [4:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] s);
    case (op)
      C_AND:          return x & y;
      C_OR:           return x | y;
      C_XOR:          return x ^ y;
      C_NOR:          return ~(x | y);
      C_ADD, C_ADDU:  return x + y;
      C_SUB, C_SUBU:  return x - y;
      C_SLT:          return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      C_SLTU:         return (x < y) ? 32'd1 : 32'd0;
      C_LUI:          return y * 32'h10000;
      C_SLL:          return y << s;
      C_SRL:          return y >> s;
      C_SRA:          return $unsigned($signed(y) >>> s);
      C_SLLV:         return y << x[4:0];
      C_SRLV:         return y >> x[4:0];
      C_SRAV:         return $unsigned($signed(y) >>> x[4:0]);
      C_MFHI:         return m_hi;
      C_MFLO:         return m_lo;
      C_MTHI, C_MTLO: return x;
      default:        return 32'd0;
    endcase
  endfunction

  // Overflow as "true signed result outside the 32-bit range".
  function automatic logic m_ovf(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint r;
    if (op == C_ADD)      r = longint'($signed(x)) + longint'($signed(y));
    else if (op == C_SUB) r = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic comb_vec(input string tag, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] s,
                          input logic [31:0] exp_r, input logic exp_o);
    bus.ex_valid = 1'b0; bus.flush = 1'b0;
    bus.alucontrol = op; bus.a = x; bus.b = y; bus.sa = s;
    #2;
    check({tag, "_res"}, bus.result, exp_r);
    check({tag, "_ovf"}, bus.overflow, exp_o);
    @(posedge clk); #1;
  endtask

  // Issues a divide held with ex_valid; flush_at<0 means no flush, else the cycle index of the pulse.
  task automatic do_div(input string tag, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int flush_at);
    int n;
    int exp_n;
    longint q, r;
    n = 0;
    bus.ex_valid = 1'b1; bus.alucontrol = op; bus.a = x; bus.b = y; bus.sa = '0;
    for (int k = 0; k < 60; k++) begin
      bus.flush = (k == flush_at);
      if (flush_at >= 0 && k > flush_at) bus.ex_valid = 1'b0;
      if (k > 0) begin
        bus.alucontrol = C_ADD; bus.a = $urandom; bus.b = $urandom;
      end
      #2;
      if (!bus.busy) break;
      n++;
      @(posedge clk); #1;
    end
    bus.ex_valid = 1'b0; bus.alucontrol = C_USELESS;
    @(posedge clk); #1;
    bus.flush = 1'b0;
`ifdef ALU_HILO_DIV_EN
    exp_n = (flush_at >= 1 && flush_at <= 32) ? flush_at + 1 : 33;
    if (flush_at < 0 && y != 32'h0) begin
      if (op == C_DIV) begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
      end else begin
        q = longint'({32'h0, x}) / longint'({32'h0, y});
        r = longint'({32'h0, x}) % longint'({32'h0, y});
      end
      m_lo = q[31:0];
      m_hi = r[31:0];
    end
`else
    exp_n = 0;
`endif
    check({tag, "_busy_cycles"}, n, exp_n);
    check({tag, "_hi"}, bus.hi_o, m_hi);
    check({tag, "_lo"}, bus.lo_o, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] x, y;
    logic [4:0]  s;
    logic        ev, fl;
    longint      p;

    resetn = 1'b0;
    bus.ex_valid = 1'b0; bus.flush = 1'b0; bus.alucontrol = C_USELESS;
    bus.a = '0; bus.b = '0; bus.sa = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_hi", bus.hi_o, 32'h0);
    check("reset_lo", bus.lo_o, 32'h0);
    check("reset_busy", bus.busy, 1'b0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    comb_vec("add_ovf",   C_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
    comb_vec("addu_novf", C_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0);
    comb_vec("sub_ovf",   C_SUB,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1);
    comb_vec("sra",       C_SRA,  32'h0, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0);
    comb_vec("sltu",      C_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b0);
    comb_vec("slt",       C_SLT,  32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
    comb_vec("lui",       C_LUI,  32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 1'b0);
    comb_vec("undef",     5'd31,  32'h5, 32'h7, 5'd3, 32'h0, 1'b0);

    bus.ex_valid = 1'b1; bus.alucontrol = C_MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
    #2;
    check("mult_res", bus.result, 32'h0);
    @(posedge clk); #1;
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    check("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo_o, 32'hFFFF_FFFA);
    bus.alucontrol = C_MFLO;
    #2;
    check("mflo", bus.result, 32'hFFFF_FFFA);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      do op = 5'($urandom_range(0, 31)); while (op == C_DIV || op == C_DIVU);
      x = pick_operand(); y = pick_operand(); s = 5'($urandom_range(0, 31));
      if (op == C_SUB && y == 32'h8000_0000) y = 32'h8000_0001;
      ev = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 4) == 0);
      bus.ex_valid = ev; bus.flush = fl; bus.alucontrol = op; bus.a = x; bus.b = y; bus.sa = s;
      #2;
      check("rand_res", bus.result, m_res(op, x, y, s));
      check("rand_ovf", bus.overflow, m_ovf(op, x, y));
      check("rand_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
      if (ev && !fl) begin
        case (op)
          C_MTHI:  m_hi = x;
          C_MTLO:  m_lo = x;
          C_MULT: begin
            p = longint'($signed(x)) * longint'($signed(y));
            m_hi = p[63:32]; m_lo = p[31:0];
          end
          C_MULTU: begin
            p = longint'({32'h0, x}) * longint'({32'h0, y});
            m_hi = p[63:32]; m_lo = p[31:0];
          end
          default: ;
        endcase
      end
      check("rand_hi", bus.hi_o, m_hi);
      check("rand_lo", bus.lo_o, m_lo);
    end
    bus.flush = 1'b0; bus.ex_valid = 1'b0;

    do_div("div_neg7_2",   C_DIV,  32'hFFFF_FFF9, 32'd2, -1);
    do_div("divu_by0",     C_DIVU, 32'd7, 32'd0, -1);
    do_div("div_minneg1",  C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_div("divu_flush10", C_DIVU, 32'd100, 32'd7, 10);
    do_div("divu_100_7",   C_DIVU, 32'd100, 32'd7, -1);
    do_div("div_flushdone", C_DIV, 32'd1000, 32'hFFFF_FFFD, 33);
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom >> $urandom_range(0, 31);
      do_div("div_rand", (i % 2 == 0) ? C_DIV : C_DIVU, x, y, -1);
    end

    bus.ex_valid = 1'b1; bus.alucontrol = C_DIVU; bus.a = 32'd50; bus.b = 32'd3;
    #2;
`ifdef ALU_HILO_DIV_EN
    check("rst_mid_busy_pre", bus.busy, 1'b1);
`else
    check("rst_mid_busy_pre", bus.busy, 1'b0);
`endif
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0; bus.ex_valid = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_hi", bus.hi_o, m_hi);
    check("rst_mid_lo", bus.lo_o, m_lo);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_after_busy", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
